// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory port for the RV32I MemRW path.
// Checks access legality, drives a request/ack bus with byte lanes, formats
// load data and stalls the pipeline until the access finishes or times out.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Counter value in the last ACCESS cycle before timeout fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        done_q;
  logic        access_err_q;
  logic        bus_err_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] load_data_q;

  logic        is_ld;
  logic        is_st;
  logic        new_acc;
  logic        legal;
  logic [7:0]  cnt_d;

  // Selects the addressed byte/half of the read word and extends it.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] st_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so any enabled lane carries it.
  function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  return {4{sd[7:0]}};
      3'b001:  return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  // Decode the incoming command and its size/alignment legality.
  always_comb begin
    is_ld   = (mem_rw == 2'b10);
    is_st   = (mem_rw == 2'b01);
    new_acc = req_valid & (is_ld | is_st);
    legal   = 1'b0;
    if (is_ld) begin
      case (funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~addr[0];
        3'b010:         legal = (addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end else if (is_st) begin
      case (funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~addr[0];
        3'b010:  legal = (addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      ld_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      done_q       <= 1'b0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      load_data_q  <= 32'd0;
    end else begin
      done_q       <= 1'b0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (new_acc && legal) begin
            state_q     <= S_ACCESS;
            cnt_q       <= 8'd0;
            ld_q        <= is_ld;
            f3_q        <= funct3;
            off_q       <= addr[1:0];
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_st;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= is_st ? st_be(funct3, addr[1:0]) : 4'b1111;
            bus_wdata_q <= is_st ? st_wdata(funct3, store_data) : 32'd0;
          end else if (new_acc) begin
            access_err_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_d;
          // An ack always wins over a timeout landing in the same cycle.
          if (bus_ack || cnt_q == TO_LAST) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            bus_err_q   <= ~bus_ack;
            load_data_q <= (bus_ack && ld_q) ? fmt_load(f3_q, off_q, bus_rdata) : 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall      = ((state_q == S_IDLE) && new_acc && legal) || (state_q == S_ACCESS);
  assign done       = done_q;
  assign load_data  = load_data_q;
  assign access_err = access_err_q;
  assign bus_err    = bus_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
